// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core coherence bus: word type, RAM status, request kinds.
// No logic beyond the round-robin pick helper.
package cpu_types_pkg;
    localparam int CPUS = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {REQ_DWB, REQ_INV, REQ_DRD, REQ_IFETCH} req_kind_t;

    // Both cores asking: the rr bit names the winner; otherwise the lone requester wins.
    function automatic logic rr_pick(input logic [CPUS-1:0] req, input logic rr);
        return (&req) ? rr : req[1];
    endfunction
endpackage

// File: rtl/coherence_bus_if.sv
// Cache-side and RAM-side signal bundle of the coherence bus.
// slave = bus controller view, master = caches/RAM view.
interface coherence_bus_if;
    import cpu_types_pkg::*;

    logic  [CPUS-1:0] iREN;
    word_t [CPUS-1:0] iaddr;
    logic  [CPUS-1:0] dREN;
    logic  [CPUS-1:0] dWEN;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic  [CPUS-1:0] ccwrite;
    logic  [CPUS-1:0] iwait;
    logic  [CPUS-1:0] dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;
    logic  [CPUS-1:0] ccwait;
    logic  [CPUS-1:0] ccinv;
    word_t [CPUS-1:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    word_t            ramload;
    ramstate_t        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ramload, ramstate,
        output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ramload, ramstate,
        input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/bus_arbiter.sv
// Priority + round-robin grant: dWEN > invalidate > dREN > iREN, core tie broken by rr.
// Latency: combinational; backpressure: none, the grant is only consumed in IDLE.
module bus_arbiter
    import cpu_types_pkg::*;
(
    input  logic [CPUS-1:0] dwen_req,
    input  logic [CPUS-1:0] inv_req,
    input  logic [CPUS-1:0] dren_req,
    input  logic [CPUS-1:0] iren_req,
    input  logic            rr,
    output logic            gnt_vld,
    output logic            gnt_core,
    output req_kind_t       gnt_kind
);
    always_comb begin
        gnt_vld  = 1'b1;
        gnt_core = 1'b0;
        gnt_kind = REQ_IFETCH;
        if (|dwen_req) begin
            gnt_kind = REQ_DWB;
            gnt_core = rr_pick(dwen_req, rr);
        end else if (|inv_req) begin
            gnt_kind = REQ_INV;
            gnt_core = rr_pick(inv_req, rr);
        end else if (|dren_req) begin
            gnt_kind = REQ_DRD;
            gnt_core = rr_pick(dren_req, rr);
        end else if (|iren_req) begin
            gnt_kind = REQ_IFETCH;
            gnt_core = rr_pick(iren_req, rr);
        end else begin
            gnt_vld = 1'b0;
        end
    end
endmodule

// File: rtl/coherence_bus.sv
// Two-core snooping bus controller in front of a single RAM port (MSI-style snoop/invalidate, cache-to-cache).
// Latency: grant in IDLE, >=1 RAM cycle per transfer, +1 for snoop; backpressure: requester held via iwait/dwait until ACCESS.
module coherence_bus
    import cpu_types_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    coherence_bus_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IFETCH, DWB, SNOOP, DRD, C2C, INV} state_t;

    state_t    state_q, state_d;
    logic      rr_q, rr_d;
    logic      gnt_q, gnt_d;
    word_t     buf_q, buf_d;

    logic      gnt_vld;
    logic      gnt_core;
    req_kind_t gnt_kind;
    logic      c, o;
    logic      ram_done, ram_err;

    assign c        = gnt_q;
    assign o        = ~gnt_q;
    assign ram_done = (bus.ramstate == ACCESS);
    assign ram_err  = (bus.ramstate == ERROR);

    // A bare ccwrite in IDLE is a write-hit invalidate, not a snoop reply.
    bus_arbiter u_arb (
        .dwen_req (bus.dWEN),
        .inv_req  (bus.ccwrite & ~bus.dREN & ~bus.dWEN),
        .dren_req (bus.dREN),
        .iren_req (bus.iREN),
        .rr       (rr_q),
        .gnt_vld  (gnt_vld),
        .gnt_core (gnt_core),
        .gnt_kind (gnt_kind)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        buf_d   = buf_q;

        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.iload       = '0;
        bus.dload       = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    rr_d  = ~rr_q;
                    gnt_d = gnt_core;
                    case (gnt_kind)
                        REQ_DWB:    state_d = DWB;
                        REQ_INV:    state_d = INV;
                        REQ_DRD:    state_d = SNOOP;
                        REQ_IFETCH: state_d = IFETCH;
                    endcase
                end
            end
            IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[c];
                if (ram_done && bus.iREN[c]) begin
                    bus.iwait[c] = 1'b0;
                    bus.iload[c] = bus.ramload;
                end
                if (ram_done || ram_err) state_d = IDLE;
            end
            DWB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr[c];
                bus.ramstore = bus.dstore[c];
                if (ram_done && bus.dWEN[c]) bus.dwait[c] = 1'b0;
                if (ram_done || ram_err) state_d = IDLE;
            end
            SNOOP: begin
                bus.ccwait[o]      = 1'b1;
                bus.ccsnoopaddr[o] = bus.daddr[c];
                if (!bus.dREN[c]) begin
                    state_d = IDLE;
                end else if (bus.ccwrite[o]) begin
                    buf_d   = bus.dstore[o];
                    state_d = C2C;
                end else begin
                    state_d = DRD;
                end
            end
            DRD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.daddr[c];
                if (ram_done && bus.dREN[c]) begin
                    bus.dwait[c] = 1'b0;
                    bus.dload[c] = bus.ramload;
                end
                if (ram_done || ram_err) state_d = IDLE;
            end
            C2C: begin
                // Modified line supplied by the other cache is also written through to RAM.
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr[c];
                bus.ramstore = buf_q;
                if (ram_done && bus.dREN[c]) begin
                    bus.dwait[c] = 1'b0;
                    bus.dload[c] = buf_q;
                end
                if (ram_done || ram_err) state_d = IDLE;
            end
            INV: begin
                bus.ccwait[o]      = 1'b1;
                bus.ccinv[o]       = 1'b1;
                bus.ccsnoopaddr[o] = bus.daddr[c];
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: doc/coherence_bus.md
COHERENCE_BUS -- requirements
Module: coherence_bus

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports iREN[1:0] in 1 each, iaddr[1:0] in 32 each: per-core instruction fetch request and address.
REQ-004 SHALL have ports dREN[1:0], dWEN[1:0] in 1 each, daddr[1:0], dstore[1:0] in 32 each: per-core dcache read/write request, word address, store data.
REQ-005 SHALL have ports iwait[1:0], dwait[1:0] out 1 each, iload[1:0], dload[1:0] out 32 each: busy flags (low = transfer complete this cycle) and returned data.
REQ-006 SHALL have ports ccwrite[1:0] in 1 each: snoop-hit-Modified response while snooped; write-hit invalidate request otherwise.
REQ-007 SHALL have ports ccwait[1:0], ccinv[1:0] out 1 each, ccsnoopaddr[1:0] out 32 each: snoop strobe, invalidate qualifier, snoop address.
REQ-008 SHALL have ports ramREN, ramWEN out 1, ramaddr, ramstore out 32, ramload in 32, ramstate in ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-009 Output defaults (every cycle unless overridden): iwait=dwait=2'b11, ccwait=ccinv=0, ccsnoopaddr=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-010 States: IDLE, IFETCH, DWB, SNOOP, DRD, C2C, INV.
REQ-011 IDLE arbitration priority: dWEN > ccwrite-invalidate > dREN > iREN; ties between cores resolved round-robin via one rr bit, toggled on every grant; grantee core id registered.
REQ-012 IDLE -> DWB on dWEN[c]: ramWEN=1, ramaddr=daddr[c], ramstore=dstore[c]; on ramstate==ACCESS dwait[c]=0, -> IDLE same edge.
REQ-013 IDLE -> INV on ccwrite[c] with dREN[c]=dWEN[c]=0: one cycle ccwait[~c]=1, ccinv[~c]=1, ccsnoopaddr[~c]=daddr[c]; -> IDLE. Requesting dcache keeps daddr valid during write hit.
REQ-014 IDLE -> SNOOP on dREN[c]: one cycle ccwait[~c]=1, ccinv[~c]=0, ccsnoopaddr[~c]=daddr[c]; if ccwrite[~c]=1 same cycle, latch dstore[~c] into 32-bit c2c buffer, -> C2C; else -> DRD.
REQ-015 DRD: ramREN=1, ramaddr=daddr[c]; on ACCESS dload[c]=ramload, dwait[c]=0, -> IDLE.
REQ-016 C2C: ramWEN=1, ramaddr=daddr[c], ramstore=buffer (memory write-through of supplied line word); on ACCESS dload[c]=buffer, dwait[c]=0, -> IDLE.
REQ-017 IDLE -> IFETCH on iREN[c]: ramREN=1, ramaddr=iaddr[c]; on ACCESS iload[c]=ramload, iwait[c]=0, -> IDLE.
REQ-018 ramstate==ERROR in any transfer state: abort, -> IDLE, wait lines stay high (requester retries).
REQ-019 Minimum latency: DRD/IFETCH/DWB complete no earlier than 1 cycle after grant; SNOOP adds exactly 1 cycle.
REQ-020 Request withdrawn (REN/WEN low) mid-transfer: finish current RAM cycle, discard result, -> IDLE.
REQ-021 ccwait asserted only toward the non-requesting core, never both, never in IDLE.

Reset
REQ-022 RST=1 at an edge: state=IDLE, rr=0, grantee=0, buffer=0; outputs at REQ-009 defaults from next cycle, aborting any RAM transfer.

Structure
REQ-023 ramstate_t, word_t and CPUS=2 SHALL live in cpu_types_pkg; state enum local.
REQ-024 Round-robin selection SHALL be one sub-module, bus_arbiter (request vectors + rr bit in, grant core/type out).

Verification
REQ-025 dREN[0], daddr=0x100, core1 no ccwrite, RAM ACCESS after 2 cycles -> ccwait[1]=1 one cycle, dload[0]=ramload, dwait[0] low one cycle.
REQ-026 dREN[0] addr 0x200, core1 ccwrite=1, dstore[1]=0xDEADBEEF -> C2C, ramWEN to 0x200 with 0xDEADBEEF, dload[0]=0xDEADBEEF.
REQ-027 dWEN[0] and dREN[1] and iREN[0] same cycle -> DWB core0 first, then SNOOP core1, then IFETCH core0.
REQ-028 iREN both cores held 4 transactions -> grants alternate 0,1,0,1.
REQ-029 ccwrite[1] alone, daddr[1]=0x300 -> ccwait[0]=ccinv[0]=1, ccsnoopaddr[0]=0x300 for exactly one cycle.
REQ-030 RST asserted mid-DRD -> next cycle ramREN=0, state IDLE, all waits high.
